// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR configuration path:
// loader FSM states, frame targets and error codes.
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_e;

    localparam logic TGT_TAP  = 1'b0;
    localparam logic TGT_SEED = 1'b1;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_SHORT   = 2'b01;
    localparam logic [1:0] ERR_OVERRUN = 2'b10;
    localparam logic [1:0] ERR_ZERO    = 2'b11;

endpackage

// File: rtl/shift_reg_en.sv
// Serial-in, MSB-first shift register with synchronous clear and clock enable.
// Clear wins over enable.
module shift_reg_en #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic         d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;

    // Shadow storage: clear, shift on enable, otherwise hold.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            q_q <= {W{1'b0}};
        end else if (en_i) begin
            q_q <= {q_q[W-2:0], d_i};
        end else begin
            q_q <= q_q;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/lfsr_cfg_loader.sv
// Serial tap/seed loader: shifts a frame into a shadow register, validates length
// and value, then commits it to the targeted active register in one cycle.
module lfsr_cfg_loader
    import lfsr_pkg::*;
#(
    parameter int                  REG_SIZE   = 8,
    parameter logic [REG_SIZE-1:0] TAP_RESET  = 8'hB8,
    parameter logic [REG_SIZE-1:0] SEED_RESET = 8'h01
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_start,
    input  logic                cfg_sel,
    input  logic                load,
    input  logic                tap_in,
    input  logic                cfg_end,
    output logic [REG_SIZE-1:0] tap_reg,
    output logic [REG_SIZE-1:0] seed_reg,
    output logic                cfg_done,
    output logic                cfg_err,
    output logic [1:0]          err_code,
    output logic                busy
);

    localparam int            CW       = $clog2(REG_SIZE + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(REG_SIZE);
    // One past full marks an overrun; the counter parks there.
    localparam logic [CW-1:0] CNT_MAX  = CW'(REG_SIZE + 1);

    state_e              state_q, state_d;
    logic [CW-1:0]       count_q;
    logic                target_q;
    logic [REG_SIZE-1:0] tap_q, seed_q;
    logic                done_q, err_q;
    logic [1:0]          code_q;

    logic [REG_SIZE-1:0] shadow_s;
    logic [CW-1:0]       cnt_inc_s, cnt_nxt_s;
    logic                start_s, shift_en_s, clr_s;

    assign start_s    = cfg_start && ((state_q == IDLE) || (state_q == SHIFT));
    assign shift_en_s = (state_q == SHIFT) && load && !cfg_start;
    assign clr_s      = reset || start_s;
    assign cnt_inc_s  = (count_q == CNT_MAX) ? count_q : (count_q + CW'(1));
    assign cnt_nxt_s  = load ? cnt_inc_s : count_q;

    shift_reg_en #(.W(REG_SIZE)) u_shadow (
        .clk   (clk),
        .clr_i (clr_s),
        .en_i  (shift_en_s),
        .d_i   (tap_in),
        .q_o   (shadow_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; a restart takes priority over end-of-frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cfg_start) state_d = SHIFT;
                else           state_d = IDLE;
            end
            SHIFT: begin
                if (cfg_start)                  state_d = SHIFT;
                else if (!cfg_end)              state_d = SHIFT;
                else if (cnt_nxt_s == CNT_FULL) state_d = COMMIT;
                else                            state_d = IDLE;
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM output logic.
    always_comb begin
        busy = (state_q != IDLE);
    end

    // Frame counter, status pulses and active register commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= {CW{1'b0}};
            target_q <= TGT_TAP;
            tap_q    <= TAP_RESET;
            seed_q   <= SEED_RESET;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= ERR_NONE;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (start_s) begin
                count_q  <= {CW{1'b0}};
                target_q <= cfg_sel;
                code_q   <= ERR_NONE;
            end else if (state_q == SHIFT) begin
                count_q <= cnt_nxt_s;
                if (cfg_end && (cnt_nxt_s < CNT_FULL)) begin
                    err_q  <= 1'b1;
                    code_q <= ERR_SHORT;
                end else if (cfg_end && (cnt_nxt_s > CNT_FULL)) begin
                    err_q  <= 1'b1;
                    code_q <= ERR_OVERRUN;
                end else begin
                    code_q <= code_q;
                end
            end else if (state_q == COMMIT) begin
                if (shadow_s == {REG_SIZE{1'b0}}) begin
                    err_q  <= 1'b1;
                    code_q <= ERR_ZERO;
                end else if (target_q == TGT_SEED) begin
                    seed_q <= shadow_s;
                    done_q <= 1'b1;
                end else begin
                    tap_q  <= shadow_s;
                    done_q <= 1'b1;
                end
            end else begin
                count_q <= count_q;
            end
        end
    end

    assign tap_reg  = tap_q;
    assign seed_reg = seed_q;
    assign cfg_done = done_q;
    assign cfg_err  = err_q;
    assign err_code = code_q;

endmodule

// File: tb/tb_lfsr_cfg_loader.sv
// Directed self-checking bench for lfsr_cfg_loader with hand-computed expectations.
module tb_lfsr_cfg_loader;

    logic       clk = 1'b0;
    logic       reset, cfg_start, cfg_sel, load, tap_in, cfg_end;
    logic [7:0] tap_reg, seed_reg;
    logic       cfg_done, cfg_err, busy;
    logic [1:0] err_code;

    int errors = 0;
    int checks = 0;

    lfsr_cfg_loader #(.REG_SIZE(8), .TAP_RESET(8'hB8), .SEED_RESET(8'h01)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_start (cfg_start),
        .cfg_sel   (cfg_sel),
        .load      (load),
        .tap_in    (tap_in),
        .cfg_end   (cfg_end),
        .tap_reg   (tap_reg),
        .seed_reg  (seed_reg),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .err_code  (err_code),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic sel);
        cfg_start = 1'b1;
        cfg_sel   = sel;
        cyc();
        cfg_start = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            load   = 1'b1;
            tap_in = bits[i];
            cyc();
        end
        load   = 1'b0;
        tap_in = 1'b0;
    endtask

    task automatic end_frame();
        cfg_end = 1'b1;
        cyc();
        cfg_end = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cfg_start = 1'b0; cfg_sel = 1'b0;
        load = 1'b0; tap_in = 1'b0; cfg_end = 1'b0;

        // 1 reset
        cyc(); cyc();
        reset = 1'b0;
        check("rst_tap",  tap_reg,  32'h00B8);
        check("rst_seed", seed_reg, 32'h0001);
        check("rst_busy", busy,     32'h0);
        check("rst_code", err_code, 32'h0);
        check("rst_done", cfg_done, 32'h0);

        // 2 tap load 1011_0100
        start_frame(1'b0);
        check("start_busy", busy, 32'h1);
        send_bits(16'h00B4, 8);
        end_frame();
        check("pre_commit_tap",  tap_reg,  32'h00B8);
        check("pre_commit_done", cfg_done, 32'h0);
        check("commit_busy",     busy,     32'h1);
        cyc();
        check("tap_b4",     tap_reg,  32'h00B4);
        check("tap_done",   cfg_done, 32'h1);
        check("tap_seed",   seed_reg, 32'h0001);
        check("tap_noerr",  cfg_err,  32'h0);
        cyc();
        check("done_pulse", cfg_done, 32'h0);
        check("idle_busy",  busy,     32'h0);

        // 3 short then overrun
        start_frame(1'b0);
        send_bits(16'h0055, 7);
        end_frame();
        check("short_err",  cfg_err,  32'h1);
        check("short_code", err_code, 32'h1);
        check("short_busy", busy,     32'h0);
        cyc();
        check("short_pulse", cfg_err,  32'h0);
        check("short_hold",  err_code, 32'h1);
        check("short_tap",   tap_reg,  32'h00B4);
        start_frame(1'b0);
        check("start_clr_code", err_code, 32'h0);
        send_bits(16'h01FF, 9);
        end_frame();
        check("over_err",  cfg_err,  32'h1);
        check("over_code", err_code, 32'h2);
        cyc();
        check("over_tap",  tap_reg,  32'h00B4);

        // 4 zero seed
        start_frame(1'b1);
        send_bits(16'h0000, 8);
        end_frame();
        check("zero_noerr_yet", cfg_err, 32'h0);
        cyc();
        check("zero_err",  cfg_err,  32'h1);
        check("zero_code", err_code, 32'h3);
        check("zero_done", cfg_done, 32'h0);
        check("zero_seed", seed_reg, 32'h0001);

        // 5a last bit with cfg_end in the same cycle: seed 0101_1010
        start_frame(1'b1);
        send_bits(16'h002D, 7);
        load = 1'b1; tap_in = 1'b0; cfg_end = 1'b1;
        cyc();
        load = 1'b0; cfg_end = 1'b0;
        check("same_cyc_busy", busy, 32'h1);
        cyc();
        check("same_cyc_seed", seed_reg, 32'h005A);
        check("same_cyc_done", cfg_done, 32'h1);
        check("same_cyc_tap",  tap_reg,  32'h00B4);

        // 5b restart after 4 bits, with load high on the restart cycle
        start_frame(1'b0);
        send_bits(16'h000F, 4);
        load = 1'b1; tap_in = 1'b1;
        start_frame(1'b0);
        load = 1'b0;
        send_bits(16'h003C, 8);
        end_frame();
        cyc();
        check("restart_tap",  tap_reg,  32'h003C);
        check("restart_done", cfg_done, 32'h1);

        // 5c reset mid-frame
        start_frame(1'b1);
        send_bits(16'h001F, 5);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("mid_rst_tap",  tap_reg,  32'h00B8);
        check("mid_rst_seed", seed_reg, 32'h0001);
        check("mid_rst_busy", busy,     32'h0);
        end_frame();
        check("idle_end_err",  cfg_err, 32'h0);
        check("idle_end_busy", busy,    32'h0);

        // 6 idle loads ignored, then gapped frame 1000_0001
        load = 1'b1; tap_in = 1'b1;
        cyc(); cyc(); cyc();
        load = 1'b0;
        check("idle_load_busy", busy, 32'h0);
        start_frame(1'b0);
        for (int i = 7; i >= 0; i--) begin
            load   = 1'b1;
            tap_in = (i == 7 || i == 0) ? 1'b1 : 1'b0;
            cyc();
            load   = 1'b0;
            tap_in = 1'b1;
            cyc(); cyc(); cyc();
        end
        end_frame();
        cyc();
        check("gap_tap",  tap_reg,  32'h0081);
        check("gap_done", cfg_done, 32'h1);
        check("gap_seed", seed_reg, 32'h0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
